reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port register file with per-register scoreboard for the pipelined MIPS core. Provides two asynchronous read ports, two synchronous write-back ports with byte strobes, optional write-to-read bypass, and a busy bit per register. The busy bit is set at instruction issue and cleared at write-back, so the issue stage can detect RAW hazards. Register 0 reads as zero, is never written and is never busy.

## Interface
- DATA_WIDTH, 32: register width; multiple of 8.
- ADDR_WIDTH, 5: register index width; depth is 2^ADDR_WIDTH.
- BYPASS, 1: 1 = reads return same-cycle write data; 0 = reads return stored value only.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- raddr1, raddr2  in  ADDR_WIDTH  read addresses.
- rdata1, rdata2  out  DATA_WIDTH  read data (combinational).
- rbusy1, rbusy2  out  1  busy bit of raddr1/raddr2 (combinational).
- wen0, wen1  in  1  write enables; port 1 is the younger write.
- waddr0, waddr1  in  ADDR_WIDTH  write addresses.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- wstrb0, wstrb1  in  DATA_WIDTH/8  byte enables; bit k covers bits [8k+7:8k].
- issue_en  in  1  mark issue_addr busy.
- issue_addr  in  ADDR_WIDTH  destination register of the issuing instruction.
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH registers, plus a busy vector of the same depth.
- Write: at posedge, if wenN and waddrN != 0, update each byte whose wstrbN bit is set. Bytes with a clear strobe bit keep their old value.
- Dual write to the same address in one cycle: merge per byte. Where both strobes are set, port 1 wins. Where only one strobe is set, that port's byte is written.
- Busy clear: wenN with waddrN != 0 clears busy[waddrN], regardless of strobe value (including all-zero strobe).
- Busy set: issue_en with issue_addr != 0 sets busy[issue_addr].
- Set and clear of the same register in one cycle: set wins; the register stays busy.
- Issuing to a register that is already busy: stays busy; busy_cnt unchanged.
- busy_cnt always equals the population count of the busy vector.
  - Maintain it incrementally with a registered counter: +1 per 0→1 transition, −1 per 1→0 transition. Two clears and one set can land in one cycle.
  - The counter must never underflow or overflow.
- Read with BYPASS=0: rdataN = stored[raddrN].
- Read with BYPASS=1: rdataN = the value the register will hold after this edge. That is the stored value, overlaid with strobed bytes from port 0, then overlaid with strobed bytes from port 1 (per-byte priority).
- rbusyN always reflects the registered busy vector; it is never bypassed.
- Address 0: rdataN = 0 and rbusyN = 0 in all cases, including when a write or issue targets address 0.
- Reset: all registers = 0, all busy bits = 0, busy_cnt = 0. rst overrides every write and issue in the same cycle.

## Timing
- Read data and busy outputs: zero-cycle combinational from raddr and state.
- Write data is visible via the stored path from the cycle after the edge. With BYPASS=1 it is also visible in the same cycle.
- Busy set/clear is visible on rbusyN and busy_cnt in the cycle after the edge.
- Reset takes effect at the first posedge with rst=1. Outputs are zero from that cycle on, until the first post-reset write or issue.
- Asserting rst mid-operation (busy registers outstanding) drops all busy bits and busy_cnt to 0 in one cycle.
- No back-pressure; every enable is accepted every cycle.

## Test plan
- Reset, then read all addresses → rdata = 0, rbusy = 0, busy_cnt = 0.
- Write 0xDEADBEEF to r5 with strb=4'b1111, then strb=4'b0010 with data 0x00001200 → r5 reads 0xDEAD12EF.
- Same cycle: wen0 r7 = 0x11111111 strb 4'b1111, wen1 r7 = 0x22222222 strb 4'b0101 → r7 = 0x11221122 next cycle. With BYPASS=1, raddr1=7 shows 0x11221122 in the write cycle.
- Issue r3, r4, r3 in consecutive cycles → busy_cnt 1, 2, 2. Then write r3 plus issue r3 in the same cycle → r3 stays busy, busy_cnt = 2. Then write r3 and r4 together → busy_cnt = 0.
- Write 0xFFFFFFFF to r0 and issue r0 → rdata = 0, rbusy = 0, busy_cnt unchanged.
- Issue r1..r31, then assert rst for one cycle → busy_cnt = 0 and all registers = 0 on the next cycle. busy_cnt reached 31 before the reset, with no overflow.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with a per-register busy scoreboard.
// Two combinational read ports, two byte-strobed write-back ports (port 1 is
// the younger write), optional write-to-read bypass, and a busy counter.
// Register 0 reads as zero, is never written and is never busy.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     raddr1,
    input  logic [ADDR_WIDTH-1:0]     raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2,
    output logic                      rbusy1,
    output logic                      rbusy2,
    input  logic                      wen0,
    input  logic                      wen1,
    input  logic [ADDR_WIDTH-1:0]     waddr0,
    input  logic [ADDR_WIDTH-1:0]     waddr1,
    input  logic [DATA_WIDTH-1:0]     wdata0,
    input  logic [DATA_WIDTH-1:0]     wdata1,
    input  logic [DATA_WIDTH/8-1:0]   wstrb0,
    input  logic [DATA_WIDTH/8-1:0]   wstrb1,
    input  logic                      issue_en,
    input  logic [ADDR_WIDTH-1:0]     issue_addr,
    output logic [ADDR_WIDTH:0]       busy_cnt
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nx;
    logic [CW-1:0]         cnt_q;
    logic                  set_hit;
    logic                  cnt_inc;
    logic                  cnt_dec0;
    logic                  cnt_dec1;

    // Value a register holds after this edge: port 0 bytes, then port 1 bytes on top.
    function automatic logic [DATA_WIDTH-1:0] merge_writes(
        input logic [DATA_WIDTH-1:0] old,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] v;
        v = old;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (wen0 && (waddr0 == addr) && wstrb0[k]) v[8*k +: 8] = wdata0[8*k +: 8];
            if (wen1 && (waddr1 == addr) && wstrb1[k]) v[8*k +: 8] = wdata1[8*k +: 8];
        end
        return v;
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == 0) begin : g_zero
            // Register 0 is held at zero regardless of writes
            always_ff @(posedge clk) begin
                regs[i] <= '0;
            end
        end else begin : g_rw
            // Byte-strobed write-back with port 1 priority on overlapping bytes
            always_ff @(posedge clk) begin
                if (rst) regs[i] <= '0;
                else     regs[i] <= merge_writes(regs[i], ADDR_WIDTH'(i));
            end
        end
    end

    // Read ports: stored value, or next-edge value when bypass is enabled
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = (BYPASS != 0) ? merge_writes(regs[raddr1], raddr1) : regs[raddr1];
        if (raddr2 != '0) rdata2 = (BYPASS != 0) ? merge_writes(regs[raddr2], raddr2) : regs[raddr2];
        rbusy1 = busy[raddr1];
        rbusy2 = busy[raddr2];
    end

    // Next busy vector and the transitions it implies for the counter.
    // A clear only counts if the bit was set, the issue does not re-set it,
    // and (for port 1) port 0 is not already clearing the same register.
    always_comb begin
        set_hit = issue_en && (issue_addr != '0);
        busy_nx = busy;
        if (wen0 && (waddr0 != '0)) busy_nx[waddr0] = 1'b0;
        if (wen1 && (waddr1 != '0)) busy_nx[waddr1] = 1'b0;
        if (set_hit)                busy_nx[issue_addr] = 1'b1;
        busy_nx[0] = 1'b0;
        cnt_inc  = set_hit && !busy[issue_addr];
        cnt_dec0 = wen0 && (waddr0 != '0) && busy[waddr0]
                   && !(set_hit && (issue_addr == waddr0));
        cnt_dec1 = wen1 && (waddr1 != '0) && busy[waddr1]
                   && !(set_hit && (issue_addr == waddr1))
                   && !(wen0 && (waddr0 == waddr1));
    end

    // Busy vector and its population counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy  <= busy_nx;
            cnt_q <= cnt_q + CW'(cnt_inc) - CW'(cnt_dec0) - CW'(cnt_dec1);
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file.
module tb_reg_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NB    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2;
    logic          rbusy1, rbusy2;
    logic          wen0, wen1;
    logic [AW-1:0] waddr0, waddr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [NB-1:0] wstrb0, wstrb1;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic [AW:0]   busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wen0(wen0), .wen1(wen1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wstrb0(wstrb0), .wstrb1(wstrb1),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    // Model: register contents after the coming edge given current write inputs
    function automatic logic [DW-1:0] m_next(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == '0) return '0;
        v = m_reg[a];
        for (int k = 0; k < NB; k++) begin
            if (wen0 && waddr0 == a && wstrb0[k]) v[8*k +: 8] = wdata0[8*k +: 8];
            if (wen1 && waddr1 == a && wstrb1[k]) v[8*k +: 8] = wdata1[8*k +: 8];
        end
        return v;
    endfunction

    function automatic logic [AW:0] m_cnt();
        logic [AW:0] c;
        c = '0;
        for (int a = 0; a < DEPTH; a++) if (m_busy[a]) c = c + 1'b1;
        return c;
    endfunction

    // Advance one clock and apply the spec rules to the model
    task automatic clk_edge();
        @(posedge clk);
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_reg[a]  = '0;
                m_busy[a] = 1'b0;
            end
        end else begin
            for (int a = 1; a < DEPTH; a++) m_reg[a] = m_next(AW'(a));
            if (wen0 && waddr0 != '0) m_busy[waddr0] = 1'b0;
            if (wen1 && waddr1 != '0) m_busy[waddr1] = 1'b0;
            if (issue_en && issue_addr != '0) m_busy[issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; issue_en = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        wstrb0 = '0; wstrb1 = '0; issue_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5; wstrb0 = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd9;
        clk_edge();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            raddr1 = AW'(a); raddr2 = AW'(DEPTH - 1 - a);
            #1;
            n_cmp++;
            if (rdata1 !== '0 || rbusy1 !== 1'b0 || rdata2 !== '0) begin
                n_err++;
                $display("FAIL reset_read a=%0d: got d1=%h b1=%b d2=%h expected 0", a, rdata1, rbusy1, rdata2);
            end
        end
        n_cmp++;
        if (busy_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_strobe();
        idle();
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; wstrb0 = 4'b1111;
        clk_edge();
        wdata0 = 32'h00001200; wstrb0 = 4'b0010; raddr1 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hDEAD12EF) begin
            n_err++;
            $display("FAIL strobe_bypass: got %h expected DEAD12EF", rdata1);
        end
        clk_edge();
        idle();
        #1;
        n_cmp++;
        if (rdata1 !== 32'hDEAD12EF) begin
            n_err++;
            $display("FAIL strobe_stored: got %h expected DEAD12EF", rdata1);
        end
    endtask

    task automatic test_dual_write();
        idle();
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111; wstrb0 = 4'b1111;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222; wstrb1 = 4'b0101;
        raddr1 = 5'd7; raddr2 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h11221122) begin
            n_err++;
            $display("FAIL dual_bypass: got %h expected 11221122", rdata1);
        end
        clk_edge();
        idle();
        #1;
        n_cmp++;
        if (rdata1 !== 32'h11221122 || rdata2 !== 32'hDEAD12EF) begin
            n_err++;
            $display("FAIL dual_stored: got %h/%h expected 11221122/DEAD12EF", rdata1, rdata2);
        end
    endtask

    task automatic test_busy();
        logic [AW-1:0] seq [3];
        logic [AW:0]   exp_cnt [3];
        seq[0] = 5'd3; seq[1] = 5'd4; seq[2] = 5'd3;
        exp_cnt[0] = 6'd1; exp_cnt[1] = 6'd2; exp_cnt[2] = 6'd2;
        idle();
        raddr1 = 5'd3; raddr2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            issue_en = 1'b1; issue_addr = seq[i];
            clk_edge();
            n_cmp++;
            if (busy_cnt !== exp_cnt[i] || rbusy1 !== 1'b1) begin
                n_err++;
                $display("FAIL busy_issue%0d: got cnt=%0d b3=%b expected cnt=%0d b3=1", i, busy_cnt, rbusy1, exp_cnt[i]);
            end
        end
        idle();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0BADF00D; wstrb0 = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd3;
        #1;
        n_cmp++;
        if (rbusy1 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_not_bypassed: got %b expected 1", rbusy1);
        end
        clk_edge();
        n_cmp++;
        if (busy_cnt !== 6'd2 || rbusy1 !== 1'b1 || rdata1 !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL busy_set_wins: got cnt=%0d b3=%b d=%h expected 2/1/0BADF00D", busy_cnt, rbusy1, rdata1);
        end
        idle();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'h0;
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44444444; wstrb1 = 4'hF;
        clk_edge();
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd0 || rbusy1 !== 1'b0 || rbusy2 !== 1'b0 ||
            rdata1 !== 32'h0BADF00D || rdata2 !== 32'h44444444) begin
            n_err++;
            $display("FAIL busy_clear: got cnt=%0d b=%b%b d=%h/%h expected 0/00/0BADF00D/44444444",
                     busy_cnt, rbusy1, rbusy2, rdata1, rdata2);
        end
    endtask

    task automatic test_reg0();
        logic [AW:0] cnt_before;
        idle();
        issue_en = 1'b1; issue_addr = 5'd6;
        clk_edge();
        cnt_before = m_cnt();
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'hF;
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; wstrb1 = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        n_cmp++;
        if (rdata1 !== '0 || rbusy1 !== 1'b0) begin
            n_err++;
            $display("FAIL reg0_bypass: got d=%h b=%b expected 0/0", rdata1, rbusy1);
        end
        clk_edge();
        idle();
        #1;
        n_cmp++;
        if (rdata2 !== '0 || rbusy2 !== 1'b0 || busy_cnt !== 6'd1 || busy_cnt !== cnt_before) begin
            n_err++;
            $display("FAIL reg0_after: got d=%h b=%b cnt=%0d expected 0/0/1", rdata2, rbusy2, busy_cnt);
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            wen0 = 1'($urandom_range(0, 1));  waddr0 = AW'($urandom_range(0, 7));
            wen1 = 1'($urandom_range(0, 1));  waddr1 = AW'($urandom_range(0, 7));
            wdata0 = $urandom; wdata1 = $urandom;
            wstrb0 = NB'($urandom_range(0, 15)); wstrb1 = NB'($urandom_range(0, 15));
            issue_en = 1'($urandom_range(0, 1)); issue_addr = AW'($urandom_range(0, 7));
            raddr1 = AW'($urandom_range(0, 7)); raddr2 = AW'($urandom_range(0, 31));
            #1;
            n_cmp++;
            if (rdata1 !== m_next(raddr1) || rdata2 !== m_next(raddr2) ||
                rbusy1 !== m_busy[raddr1] || rbusy2 !== m_busy[raddr2] || busy_cnt !== m_cnt()) begin
                n_err++;
                $display("FAIL random%0d: got d=%h/%h b=%b%b cnt=%0d expected d=%h/%h b=%b%b cnt=%0d",
                         i, rdata1, rdata2, rbusy1, rbusy2, busy_cnt,
                         m_next(raddr1), m_next(raddr2), m_busy[raddr1], m_busy[raddr2], m_cnt());
            end
            clk_edge();
        end
        idle();
    endtask

    task automatic test_full_reset();
        idle();
        rst = 1'b1;
        clk_edge();
        idle();
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFEBABE; wstrb0 = 4'hF;
        for (int r = 1; r < DEPTH; r++) begin
            issue_en = 1'b1; issue_addr = AW'(r);
            clk_edge();
            wen0 = 1'b0;
            n_cmp++;
            if (busy_cnt !== (AW+1)'(r)) begin
                n_err++;
                $display("FAIL full_issue r=%0d: got cnt=%0d expected %0d", r, busy_cnt, r);
            end
        end
        issue_en = 1'b1; issue_addr = 5'd17;
        clk_edge();
        n_cmp++;
        if (busy_cnt !== 6'd31) begin
            n_err++;
            $display("FAIL full_reissue: got cnt=%0d expected 31", busy_cnt);
        end
        rst = 1'b1; wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h12345678; wstrb0 = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd2;
        clk_edge();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            raddr1 = AW'(a); raddr2 = AW'(a);
            #1;
            n_cmp++;
            if (rdata1 !== '0 || rbusy2 !== 1'b0 || busy_cnt !== '0) begin
                n_err++;
                $display("FAIL full_reset a=%0d: got d=%h b=%b cnt=%0d expected 0/0/0", a, rdata1, rbusy2, busy_cnt);
            end
        end
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0;
        for (int a = 0; a < DEPTH; a++) begin
            m_reg[a] = '0;
            m_busy[a] = 1'b0;
        end
        #2;
        test_reset();
        test_strobe();
        test_dual_write();
        test_busy();
        test_reg0();
        test_random();
        test_full_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
